// File: rtl/jr_redirect_collector.sv
// Collects single-cycle JR redirects from all SIC ports and holds the oldest one
// until the issue controller accepts it. Superseded and flushed redirects are counted.
module jr_redirect_collector #(
  parameter int NUM_SICS = 8,
  parameter int ID_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SICS-1:0]                sic_pc_redirect_valid,
  input  logic [NUM_SICS-1:0][31:0]          sic_pc_redirect_pc,
  input  logic [NUM_SICS-1:0][ID_WIDTH-1:0]  sic_pc_redirect_issue_id,
  input  logic                               rollback_trigger,
  input  logic                               redirect_ready,
  output logic                               redirect_valid,
  output logic [31:0]                        redirect_pc,
  output logic [ID_WIDTH-1:0]                redirect_issue_id,
  output logic [7:0]                         drop_count
);

  // state | meaning
  // IDLE  | nothing held, redirect_valid=0
  // PEND  | one redirect held, waiting for redirect_ready
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          drop_q, drop_d;

  logic                win_found;
  logic [31:0]         win_pc;
  logic [ID_WIDTH-1:0] win_id;
  logic [15:0]         n_valid;
  logic [15:0]         drops;
  logic [16:0]         drop_sum;

  // a older than b when the modular difference is negative
  function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction

  // strict compare keeps the lowest index on equal IDs
  always_comb begin
    win_found = 1'b0;
    win_pc    = '0;
    win_id    = '0;
    n_valid   = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (sic_pc_redirect_valid[i]) begin
        n_valid = n_valid + 16'd1;
        if (!win_found || older(sic_pc_redirect_issue_id[i], win_id)) begin
          win_found = 1'b1;
          win_pc    = sic_pc_redirect_pc[i];
          win_id    = sic_pc_redirect_issue_id[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    id_d    = id_q;
    drops   = n_valid;
    if (rollback_trigger) begin
      state_d = IDLE;
      if (state_q == PEND && !redirect_ready) drops = n_valid + 16'd1;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d = PEND;
            pc_d    = win_pc;
            id_d    = win_id;
            drops   = n_valid - 16'd1;
          end
        end
        PEND: begin
          if (redirect_ready) begin
            if (win_found) begin
              pc_d  = win_pc;
              id_d  = win_id;
              drops = n_valid - 16'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (win_found && older(win_id, id_q)) begin
            // winner loaded, displaced held entry takes its drop slot
            pc_d = win_pc;
            id_d = win_id;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    drop_sum = {9'd0, drop_q} + {1'b0, drops};
    drop_d   = (drop_sum > 17'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      id_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
      drop_q  <= drop_d;
    end
  end

  assign redirect_valid    = (state_q == PEND);
  assign redirect_pc       = pc_q;
  assign redirect_issue_id = id_q;
  assign drop_count        = drop_q;

endmodule
